// File: rtl/jtag_scan_master.sv
// JTAG scan master: turns IR/DR/TAP-reset commands into tms/tdi sequences and
// gathers tdo into a response word, parking the target TAP in RUN_TEST_IDLE.
module jtag_scan_master #(
    parameter int MAX_LEN  = 41,
    parameter int IR_LEN   = 6,
    parameter int RUN_IDLE = 3
) (
    input  logic               tclk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_TRST, S_NAV, S_SHIFT, S_POST, S_RTI_WAIT, S_RESP
    } state_e;

    typedef enum logic [1:0] {
        CMD_RESET = 2'd0, CMD_IR = 2'd1, CMD_DR = 2'd2, CMD_RSVD = 2'd3
    } cmd_e;

    state_e             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [5:0]         len_q, len_d;
    logic               is_ir_q, is_ir_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               cmd_bad;
    logic [5:0]         nav_last;

    assign cmd_bad = (cmd_type == CMD_RSVD) ||
                     ((cmd_type == CMD_DR) &&
                      ((cmd_len == 6'd0) || ({1'b0, cmd_len} > 7'(MAX_LEN))));

    // IR path walks SELECT_DR -> SELECT_IR first, so its tms preamble is one bit longer.
    assign nav_last = is_ir_q ? 6'd3 : 6'd2;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        is_ir_d    = is_ir_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        tms_d      = 1'b0;
        tdi_d      = 1'b0;

        case (state_q)
            S_INIT, S_TRST: begin
                tms_d = (cnt_q < 6'd5);
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd5) begin
                    cnt_d   = '0;
                    state_d = (state_q == S_INIT) ? S_IDLE : S_RESP;
                end
            end
            S_IDLE: begin
                if (cmd_valid) begin
                    data_d     = cmd_data;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    cnt_d      = '0;
                    is_ir_d    = (cmd_type == CMD_IR);
                    len_d      = (cmd_type == CMD_IR) ? 6'(IR_LEN) : cmd_len;
                    if (cmd_bad) begin
                        rsp_err_d = 1'b1;
                        state_d   = S_RESP;
                    end else if (cmd_type == CMD_RESET) begin
                        state_d = S_TRST;
                    end else begin
                        state_d = S_NAV;
                    end
                end
            end
            S_NAV: begin
                tms_d = (cnt_q == 6'd0) || (is_ir_q && (cnt_q == 6'd1));
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == nav_last) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                tdi_d             = data_q[cnt_q];
                tms_d             = (cnt_q == len_q - 6'd1);
                rsp_data_d[cnt_q] = tdo;
                cnt_d             = cnt_q + 6'd1;
                if (cnt_q == len_q - 6'd1) begin
                    cnt_d   = '0;
                    state_d = S_POST;
                end
            end
            S_POST: begin
                tms_d = (cnt_q == 6'd0);
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd1) begin
                    cnt_d   = '0;
                    state_d = (RUN_IDLE == 0) ? S_RESP : S_RTI_WAIT;
                end
            end
            S_RTI_WAIT: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(RUN_IDLE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge tclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            cnt_q      <= '0;
            len_q      <= '0;
            is_ir_q    <= 1'b0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            is_ir_q    <= is_ir_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Launch pins on the falling edge so the target sees settled values at its rising edge.
    always_ff @(negedge tclk or negedge rst_n) begin
        if (!rst_n) begin
            tms_q <= 1'b1;
            tdi_q <= 1'b0;
        end else begin
            tms_q <= tms_d;
            tdi_q <= tdi_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;

endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- Upstream driver for the JTAG DTM. Converts command-level IR/DR scan requests into tms/tdi bit sequences and collects tdo into a response word.
- Used by the on-chip debug bridge and by the SoC bench as the host side of the DMI path.
- Clocked by tclk, the same clock the DTM TAP uses. All outputs launch on negedge tclk; the target samples them on posedge.
- Keeps a mirror of the target TAP state and always parks the TAP in RUN_TEST_IDLE between commands.

Parameters:
- MAX_LEN, 41, maximum scan length in bits (DMI register width).
- IR_LEN, 6, instruction register length used for IR scans.
- RUN_IDLE, 3, extra RUN_TEST_IDLE cycles inserted after every UPDATE_DR/UPDATE_IR (matches the dtmcs.idle hint).

Ports:
- tclk  in  1  JTAG clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept; transfer when valid&&ready at posedge.
- cmd_type  in  2  0=TAP reset, 1=IR scan, 2=DR scan, 3=reserved.
- cmd_len  in  6  DR scan length, 1..MAX_LEN. Ignored for IR (IR_LEN is used) and for reset.
- cmd_data  in  MAX_LEN  tdi bits, LSB shifted first.
- rsp_valid  out  1  response available; held until accepted.
- rsp_ready  in  1  response accept.
- rsp_data  out  MAX_LEN  captured tdo bits, bit k = k-th shifted bit; bits >= len are 0.
- rsp_err  out  1  command rejected; no TAP activity occurred.
- tms  out  1  to DTM, changes on negedge tclk.
- tdi  out  1  to DTM, changes on negedge tclk.
- tdo  in  1  from DTM, sampled on posedge tclk.

Behaviour:
- Reset values: tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0.
- JTAG cycle definition: the value driven on a negedge is consumed by the target at the following posedge.
- State machine: INIT → IDLE → NAV → SHIFT → POST → RTI_WAIT → RESP → IDLE.
- INIT (entered after rst_n deassert):
  - drive tms=1 for 5 cycles, then tms=0 for 1 cycle (target reaches RUN_TEST_IDLE);
  - cmd_ready=1 from the posedge that consumes the final tms=0 sample (6th posedge).
- IDLE:
  - cmd_ready=1; tms=0, tdi=0 (TAP stays in RUN_TEST_IDLE).
  - On accept, latch cmd_type, length and cmd_data; deassert cmd_ready next cycle.
- Rejected commands: cmd_type=3, or DR scan with cmd_len=0 or cmd_len>MAX_LEN.
  - Go straight to RESP with rsp_err=1, rsp_data=0.
  - tms/tdi are not toggled.
- Reset command: tms=1 ×5, then tms=0 ×1. No RUN_IDLE. Go to RESP with rsp_data=0.
- NAV:
  - DR scan: tms sequence 1,0,0 (SELECT_DR → CAPTURE_DR → SHIFT_DR).
  - IR scan: tms sequence 1,1,0,0.
- SHIFT (L cycles, where L = IR_LEN or cmd_len):
  - cycle k drives tdi = data[k];
  - tms=0 for k<L-1 and tms=1 on k=L-1 (exit to EXIT1 on the last bit);
  - tdo is sampled on the same posedge that consumes tdi bit k and stored at rsp_data[k].
- POST: tms 1,0 (UPDATE → RUN_TEST_IDLE).
- RTI_WAIT: RUN_IDLE cycles with tms=0, tdi=0; skipped if RUN_IDLE=0.
- Latency (accept at posedge N):
  - rsp_valid is high after posedge N + T;
  - DR: T = 3 + L + 2 + RUN_IDLE;
  - IR: T = 4 + IR_LEN + 2 + RUN_IDLE;
  - reset: T = 6;
  - error: T = 1.
- RESP:
  - rsp_valid held with stable rsp_data and rsp_err until rsp_ready at a posedge;
  - IDLE (cmd_ready=1) on the next cycle;
  - tms stays 0 while waiting, so the TAP idles.
- tdi outside SHIFT is 0. tms/tdi are registered on negedge from posedge-computed next values, so they are glitch-free.
- rst_n asserted mid-operation: all outputs return to reset values immediately and any pending response is discarded. After release, INIT re-runs; the 5× tms=1 recovers the target TAP from any state.
- cmd_valid during INIT, busy or RESP: ignored (cmd_ready=0).

Test Plan:
- Release rst_n → tms=1 for exactly 5 posedges, then 0. cmd_ready rises at the 6th posedge. rsp_valid stays 0.
- IR scan, cmd_data=0x11, against the DTM model → target ir becomes DMI after UPDATE_IR. rsp_data=0x01 (captured 6'b000001). rsp_valid after 4+6+2+3=15 cycles.
- DR scan len 32 after IR=IDCODE(0x01), target reset → rsp_data=0x1BEEF001. rsp_valid after 3+32+2+3=40 cycles. Target ends in RUN_TEST_IDLE.
- DR scan len 41 with IR=DMI, cmd_data={addr 7'h10, data 32'h1, op 2'd2} → DMI write started by the DTM. Second scan with op=0 returns rsp_data[1:0]=0 once the target's DMI transaction has returned to IDLE.
- DR scan cmd_len=0, and cmd_type=3 → rsp_err=1 one cycle after accept, rsp_data=0, tms never 1. Hold rsp_ready=0 for 10 cycles → rsp_valid and rsp_data stable, cmd_ready=0.
- Assert rst_n low at shift bit 20 of a 41-bit scan → rsp_valid=0 and tms=1 immediately. After release, INIT sequence; a follow-up IDCODE scan returns 0x1BEEF001.
